// File: rtl/m_dram_responder_pkg.sv
// Shared encodings for the per-hart DRAM responder: funct3 access codes, FSM states
// and access-size decode helpers.
package m_dram_responder_pkg;

  localparam logic [2:0] DramCtrlB  = 3'b000;
  localparam logic [2:0] DramCtrlH  = 3'b001;
  localparam logic [2:0] DramCtrlW  = 3'b010;
  localparam logic [2:0] DramCtrlBU = 3'b100;
  localparam logic [2:0] DramCtrlHU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDone
  } resp_state_e;

  typedef enum logic [1:0] {
    SzByte,
    SzHalf,
    SzWord
  } acc_size_e;

  // Reserved funct3 codes fall through to a full-word access.
  function automatic acc_size_e ctrl_size(input logic [2:0] ctrl);
    acc_size_e sz;
    case (ctrl)
      DramCtrlB, DramCtrlBU: sz = SzByte;
      DramCtrlH, DramCtrlHU: sz = SzHalf;
      DramCtrlW:             sz = SzWord;
      default:               sz = SzWord;
    endcase
    return sz;
  endfunction

  function automatic logic ctrl_signed(input logic [2:0] ctrl);
    return (ctrl == DramCtrlB) || (ctrl == DramCtrlH);
  endfunction

endpackage

// File: rtl/m_dram_lane_align.sv
// Byte-lane steering for one word-wide access: store byte enables and replicated store data,
// plus extraction and sign/zero extension of load data.
module m_dram_lane_align
  import m_dram_responder_pkg::*;
(
  input  logic [2:0]  i_ctrl,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata_sh,
  output logic [31:0] o_rdata_ext
);

  acc_size_e   w_size;
  logic        w_sext;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_size      = ctrl_size(i_ctrl);
    w_sext      = ctrl_signed(i_ctrl);
    w_byte      = i_rdata[{i_off, 3'b000} +: 8];
    // Misaligned halfwords stay inside the containing aligned half.
    w_half      = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_be        = 4'hF;
    o_wdata_sh  = i_wdata;
    o_rdata_ext = i_rdata;
    unique case (w_size)
      SzByte: begin
        o_be        = 4'b0001 << i_off;
        o_wdata_sh  = {4{i_wdata[7:0]}};
        o_rdata_ext = {{24{w_sext & w_byte[7]}}, w_byte};
      end
      SzHalf: begin
        o_be        = i_off[1] ? 4'b1100 : 4'b0011;
        o_wdata_sh  = {2{i_wdata[15:0]}};
        o_rdata_ext = {{16{w_sext & w_half[15]}}, w_half};
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/m_dram_responder.sv
// Memory-side end of the per-hart DRAM ports: one latched request per hart, round-robin
// arbitration and a single word-wide backend access in flight.
module m_dram_responder
  import m_dram_responder_pkg::*;
#(
  parameter int unsigned NHARTS = 2,
  parameter int unsigned HID_W  = 1
) (
  input  logic                 CLK,
  input  logic                 RST_X,
  input  logic [32*NHARTS-1:0] w_dram_addr_v,
  input  logic [32*NHARTS-1:0] w_dram_wdata_v,
  input  logic [3*NHARTS-1:0]  w_dram_ctrl_v,
  input  logic [NHARTS-1:0]    w_dram_le_v,
  input  logic [NHARTS-1:0]    w_dram_we_v,
  output logic [NHARTS-1:0]    w_dram_busy_v,
  output logic [32*NHARTS-1:0] w_dram_odata_v,
  output logic [31:0]          w_grant,
  output logic                 w_mem_req,
  output logic                 w_mem_we,
  output logic [31:0]          w_mem_addr,
  output logic [31:0]          w_mem_wdata,
  output logic [3:0]           w_mem_be,
  input  logic                 w_mem_ack,
  input  logic [31:0]          w_mem_rdata
);

  logic [NHARTS-1:0] r_pend;
  logic [NHARTS-1:0] r_we;
  logic [31:0]       r_addr  [NHARTS];
  logic [31:0]       r_wdata [NHARTS];
  logic [2:0]        r_ctrl  [NHARTS];
  logic [31:0]       r_odata [NHARTS];

  logic [HID_W-1:0]  r_grant;
  logic [HID_W-1:0]  r_rr;
  logic [HID_W-1:0]  w_cand;
  logic [HID_W-1:0]  w_pick_idx;
  logic              w_pick_vld;
  logic              w_done;

  resp_state_e       r_state;
  resp_state_e       w_state_nxt;

  logic [31:0]       w_g_addr;
  logic [31:0]       w_g_wdata;
  logic [2:0]        w_g_ctrl;
  logic              w_g_we;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata_sh;
  logic [31:0]       w_rdata_ext;

  assign w_g_addr  = r_addr[r_grant];
  assign w_g_wdata = r_wdata[r_grant];
  assign w_g_ctrl  = r_ctrl[r_grant];
  assign w_g_we    = r_we[r_grant];

  m_dram_lane_align u_lane_align (
    .i_ctrl      (w_g_ctrl),
    .i_off       (w_g_addr[1:0]),
    .i_wdata     (w_g_wdata),
    .i_rdata     (w_mem_rdata),
    .o_be        (w_be),
    .o_wdata_sh  (w_wdata_sh),
    .o_rdata_ext (w_rdata_ext)
  );

  // First pending hart at or after the round-robin pointer, wrapping modulo NHARTS.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    w_cand     = '0;
    for (int i = 0; i < int'(NHARTS); i++) begin
      w_cand = HID_W'((int'(r_rr) + i) % int'(NHARTS));
      if (!w_pick_vld && r_pend[w_cand]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = w_cand;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_mem_be    = '0;
    unique case (r_state)
      StIdle: begin
        if (w_pick_vld) begin
          w_state_nxt = StIssue;
        end
      end
      StIssue: begin
        w_mem_req   = 1'b1;
        w_mem_we    = w_g_we;
        w_mem_addr  = {w_g_addr[31:2], 2'b00};
        w_mem_wdata = w_g_we ? w_wdata_sh : '0;
        w_mem_be    = w_g_we ? w_be : 4'hF;
        if (w_mem_ack) begin
          w_done      = 1'b1;
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_grant <= '0;
      r_rr    <= '0;
    end else begin
      if ((r_state == StIdle) && w_pick_vld) begin
        r_grant <= w_pick_idx;
      end
      if (w_done) begin
        r_rr <= (int'(r_grant) == int'(NHARTS) - 1) ? '0 : r_grant + 1'b1;
      end
    end
  end

  // A hart is busy from acceptance until its ack; pulses while busy are dropped.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_pend <= '0;
      r_we   <= '0;
      for (int h = 0; h < int'(NHARTS); h++) begin
        r_addr[h]  <= '0;
        r_wdata[h] <= '0;
        r_ctrl[h]  <= '0;
        r_odata[h] <= '0;
      end
    end else begin
      for (int h = 0; h < int'(NHARTS); h++) begin
        if (w_done && (r_grant == HID_W'(h))) begin
          r_pend[h] <= 1'b0;
          if (!r_we[h]) begin
            r_odata[h] <= w_rdata_ext;
          end
        end else if (!r_pend[h] && (w_dram_le_v[h] || w_dram_we_v[h])) begin
          r_pend[h]  <= 1'b1;
          r_we[h]    <= w_dram_we_v[h];
          r_addr[h]  <= w_dram_addr_v[32*h +: 32];
          r_wdata[h] <= w_dram_wdata_v[32*h +: 32];
          r_ctrl[h]  <= w_dram_ctrl_v[3*h +: 3];
        end
      end
    end
  end

  for (genvar h = 0; h < int'(NHARTS); h++) begin : g_odata
    assign w_dram_odata_v[32*h +: 32] = r_odata[h];
  end

  assign w_dram_busy_v = r_pend;
  assign w_grant       = {{(32 - HID_W){1'b0}}, r_grant};

endmodule
